mem_arbiter: RTL and testbench

//  Shares the single genrom read port (mem_addr/mem_extra -> mem_data/mem_error)

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the genrom read-port arbiter: requester IDs and the
// in-flight tag that travels alongside each access.
package mem_arbiter_pkg;

  // Requester identities: instruction fetch and data load.
  typedef enum logic {
    RQ_FETCH = 1'b0,
    RQ_LOAD  = 1'b1
  } req_id_e;

  // One pipeline tag: marks a live access and who it belongs to.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: RQ_FETCH};

  // Builds a live tag for the given requester.
  function automatic tag_t make_tag(input req_id_e id);
    return '{valid: 1'b1, id: id};
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single genrom read port. Accepts one access
// per cycle and uses a two-stage tag pipeline to steer each response back to
// its requester two edges after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 4,
  parameter int EXTRA    = 4,
  parameter int PRIORITY = 0,
  localparam int DW      = (2**EXTRA) * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [AW:0]       r0_addr,
  input  logic [EXTRA-1:0]  r0_extra,
  output logic              r0_ack,
  output logic              r0_valid,
  output logic [DW-1:0]     r0_data,
  output logic              r0_error,
  input  logic              r1_req,
  input  logic [AW:0]       r1_addr,
  input  logic [EXTRA-1:0]  r1_extra,
  output logic              r1_ack,
  output logic              r1_valid,
  output logic [DW-1:0]     r1_data,
  output logic              r1_error,
  output logic [AW:0]       mem_addr,
  output logic [EXTRA-1:0]  mem_extra,
  input  logic [DW-1:0]     mem_data,
  input  logic              mem_error
);

  logic [AW:0]      mem_addr_q, mem_addr_d;
  logic [EXTRA-1:0] mem_extra_q, mem_extra_d;
  tag_t             stage1_q, stage1_d;
  tag_t             stage2_q, stage2_d;
  req_id_e          last_grant_q, last_grant_d;
  logic             r0_valid_q, r0_valid_d;
  logic [DW-1:0]    r0_data_q, r0_data_d;
  logic             r0_error_q, r0_error_d;
  logic             r1_valid_q, r1_valid_d;
  logic [DW-1:0]    r1_data_q, r1_data_d;
  logic             r1_error_q, r1_error_d;

  // Pick at most one winner; ties go to the fixed favourite or away from the last winner.
  always_comb begin
    r0_ack = 1'b0;
    r1_ack = 1'b0;
    if (reset) begin
      if (r0_req && r1_req) begin
        if (PRIORITY == 1 || last_grant_q == RQ_LOAD) r0_ack = 1'b1;
        else                                           r1_ack = 1'b1;
      end else begin
        r0_ack = r0_req;
        r1_ack = r1_req;
      end
    end
  end

  // Launch the granted access, advance the tag pipe and steer returning data.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_extra_d  = mem_extra_q;
    stage1_d     = TAG_IDLE;
    stage2_d     = stage1_q;
    last_grant_d = last_grant_q;
    r0_valid_d   = 1'b0;
    r0_data_d    = r0_data_q;
    r0_error_d   = r0_error_q;
    r1_valid_d   = 1'b0;
    r1_data_d    = r1_data_q;
    r1_error_d   = r1_error_q;

    if (r0_ack) begin
      mem_addr_d   = r0_addr;
      mem_extra_d  = r0_extra;
      stage1_d     = make_tag(RQ_FETCH);
      last_grant_d = RQ_FETCH;
    end else if (r1_ack) begin
      mem_addr_d   = r1_addr;
      mem_extra_d  = r1_extra;
      stage1_d     = make_tag(RQ_LOAD);
      last_grant_d = RQ_LOAD;
    end

    if (stage2_q.valid) begin
      if (stage2_q.id == RQ_FETCH) begin
        r0_valid_d = 1'b1;
        r0_data_d  = mem_data;
        r0_error_d = mem_error;
      end else begin
        r1_valid_d = 1'b1;
        r1_data_d  = mem_data;
        r1_error_d = mem_error;
      end
    end
  end

  // State registers; reset drops in-flight tags so nothing returns after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q   <= '0;
      mem_extra_q  <= '0;
      stage1_q     <= TAG_IDLE;
      stage2_q     <= TAG_IDLE;
      last_grant_q <= RQ_LOAD;
      r0_valid_q   <= 1'b0;
      r0_data_q    <= '0;
      r0_error_q   <= 1'b0;
      r1_valid_q   <= 1'b0;
      r1_data_q    <= '0;
      r1_error_q   <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_extra_q  <= mem_extra_d;
      stage1_q     <= stage1_d;
      stage2_q     <= stage2_d;
      last_grant_q <= last_grant_d;
      r0_valid_q   <= r0_valid_d;
      r0_data_q    <= r0_data_d;
      r0_error_q   <= r0_error_d;
      r1_valid_q   <= r1_valid_d;
      r1_data_q    <= r1_data_d;
      r1_error_q   <= r1_error_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_extra = mem_extra_q;
  assign r0_valid  = r0_valid_q;
  assign r0_data   = r0_data_q;
  assign r0_error  = r0_error_q;
  assign r1_valid  = r1_valid_q;
  assign r1_data   = r1_data_q;
  assign r1_error  = r1_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// compared each cycle against a transaction-level model of grants and returns.
module tb_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         r0_req, r1_req;
  logic [4:0]   r0_addr, r1_addr;
  logic [3:0]   r0_extra, r1_extra;

  logic         r0_ack, r0_valid, r0_error, r1_ack, r1_valid, r1_error;
  logic [127:0] r0_data, r1_data, mem_data;
  logic [4:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic         mem_error;

  logic         p1_r0_ack, p1_r0_valid, p1_r0_error, p1_r1_ack, p1_r1_valid, p1_r1_error;
  logic [127:0] p1_r0_data, p1_r1_data, p1_mem_data;
  logic [4:0]   p1_mem_addr;
  logic [3:0]   p1_mem_extra;
  logic         p1_mem_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    int         due;
    bit         id;
    logic [8:0] val;
    bit         err;
  } resp_t;
  resp_t        pend[$];
  int           cyc = 0;
  bit           m_last;
  logic [4:0]   m_addr;
  logic [3:0]   m_extra;
  logic [127:0] m_d0, m_d1;
  bit           m_e0, m_e1;
  bit           m_ack0, m_ack1;
  int           seen_v0, seen_v1;

  mem_arbiter #(.AW(4), .EXTRA(4), .PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_extra(r0_extra), .r0_ack(r0_ack),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_error(r0_error),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_extra(r1_extra), .r1_ack(r1_ack),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_error(r1_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
  );

  mem_arbiter #(.AW(4), .EXTRA(4), .PRIORITY(1)) dut_p1 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_extra(r0_extra), .r0_ack(p1_r0_ack),
    .r0_valid(p1_r0_valid), .r0_data(p1_r0_data), .r0_error(p1_r0_error),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_extra(r1_extra), .r1_ack(p1_r1_ack),
    .r1_valid(p1_r1_valid), .r1_data(p1_r1_data), .r1_error(p1_r1_error),
    .mem_addr(p1_mem_addr), .mem_extra(p1_mem_extra), .mem_data(p1_mem_data),
    .mem_error(p1_mem_error)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // genrom stand-ins: data echoes the sampled address and size
  always @(posedge clk) begin
    mem_data     <= {119'b0, mem_addr, mem_extra};
    mem_error    <= (mem_addr == 5'h1F);
    p1_mem_data  <= {119'b0, p1_mem_addr, p1_mem_extra};
    p1_mem_error <= (p1_mem_addr == 5'h1F);
  end

  // Counts one comparison and reports it if it disagrees
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predicts this cycle's outputs from the grant rules and the pending-return queue
  task automatic modelCheck();
    bit ev0, ev1, pa0, pa1;
    ev0 = 0; ev1 = 0; pa0 = 0; pa1 = 0; m_ack0 = 0; m_ack1 = 0;
    if (!reset) begin
      pend.delete();
      m_d0 = '0; m_d1 = '0; m_e0 = 0; m_e1 = 0;
      m_addr = '0; m_extra = '0; m_last = 1;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].id == 1'b0) begin
          ev0 = 1; m_d0 = {119'b0, pend[0].val}; m_e0 = pend[0].err;
        end else begin
          ev1 = 1; m_d1 = {119'b0, pend[0].val}; m_e1 = pend[0].err;
        end
        pend.delete(0);
      end
      if (r0_req && r1_req) begin
        if (m_last) m_ack0 = 1; else m_ack1 = 1;
      end else begin
        m_ack0 = r0_req; m_ack1 = r1_req;
      end
      pa0 = r0_req;
      pa1 = r1_req && !r0_req;
    end
    checkOutput("r0_ack", r0_ack, m_ack0);
    checkOutput("r1_ack", r1_ack, m_ack1);
    checkOutput("r0_valid", r0_valid, ev0);
    checkOutput("r1_valid", r1_valid, ev1);
    checkOutput("r0_data", r0_data, m_d0);
    checkOutput("r1_data", r1_data, m_d1);
    checkOutput("r0_error", r0_error, m_e0);
    checkOutput("r1_error", r1_error, m_e1);
    checkOutput("mem_port", {mem_addr, mem_extra}, {m_addr, m_extra});
    checkOutput("p1_r0_ack", p1_r0_ack, pa0);
    checkOutput("p1_r1_ack", p1_r1_ack, pa1);
    if (r0_valid) seen_v0++;
    if (r1_valid) seen_v1++;
    if (m_ack0) begin
      pend.push_back('{due: cyc + 3, id: 1'b0, val: {r0_addr, r0_extra}, err: (r0_addr == 5'h1F)});
      m_last = 0; m_addr = r0_addr; m_extra = r0_extra;
    end else if (m_ack1) begin
      pend.push_back('{due: cyc + 3, id: 1'b1, val: {r1_addr, r1_extra}, err: (r1_addr == 5'h1F)});
      m_last = 1; m_addr = r1_addr; m_extra = r1_extra;
    end
    cyc++;
  endtask

  // Drives one cycle of inputs just after the rising edge, then checks at the falling edge
  task automatic applyStimulus(input bit rst_v,
                               input bit q0, input logic [4:0] a0, input logic [3:0] e0,
                               input bit q1, input logic [4:0] a1, input logic [3:0] e1);
    @(posedge clk);
    #1;
    reset = rst_v;
    r0_req = q0; r0_addr = a0; r0_extra = e0;
    r1_req = q1; r1_addr = a1; r1_extra = e1;
    @(negedge clk);
    modelCheck();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 5'h0, 4'h0, 0, 5'h0, 4'h0);
  endtask

  initial begin
    bit         q0, q1, rst;
    logic [4:0] a0, a1;
    logic [3:0] e0, e1;

    reset = 1'b0;
    r0_req = 1; r0_addr = 5'h1; r0_extra = 4'h0;
    r1_req = 1; r1_addr = 5'h2; r1_extra = 4'h0;
    m_last = 1; m_addr = '0; m_extra = '0;
    m_d0 = '0; m_d1 = '0; m_e0 = 0; m_e1 = 0;

    // Reset held with both requesting, then release
    applyStimulus(0, 1, 5'h1, 4'h0, 1, 5'h2, 4'h0);
    applyStimulus(0, 1, 5'h1, 4'h0, 1, 5'h2, 4'h0);
    checkOutput("t1_no_ack_in_reset", {r0_ack, r1_ack}, 2'b00);
    applyStimulus(1, 1, 5'h1, 4'h0, 0, 5'h2, 4'h0);
    checkOutput("t1_first_ack_r0", r0_ack, 1'b1);
    idle(4);

    // Single fetch
    seen_v1 = 0;
    applyStimulus(1, 1, 5'h03, 4'h2, 0, 5'h0, 4'h0);
    idle(4);
    checkOutput("t2_data", r0_data, 128'h32);
    checkOutput("t2_error", r0_error, 1'b0);
    checkOutput("t2_no_r1", seen_v1, 0);

    // Both held: alternation under round-robin, r0 only under fixed priority
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 5'h1, 4'h0, 1, 5'h2, 4'h0);
    idle(4);
    checkOutput("t3_r0_data", r0_data, 128'h10);
    checkOutput("t3_r1_data", r1_data, 128'h20);

    // Out-of-range load address
    applyStimulus(1, 0, 5'h0, 4'h0, 1, 5'h1F, 4'h0);
    idle(4);
    checkOutput("t4_data", r1_data, 128'h1F0);
    checkOutput("t4_error", r1_error, 1'b1);

    // Back-to-back fetches
    seen_v0 = 0;
    applyStimulus(1, 1, 5'h4, 4'h0, 0, 5'h0, 4'h0);
    applyStimulus(1, 1, 5'h5, 4'h0, 0, 5'h0, 4'h0);
    applyStimulus(1, 1, 5'h6, 4'h0, 0, 5'h0, 4'h0);
    idle(4);
    checkOutput("t5_pulses", seen_v0, 3);
    checkOutput("t5_last_data", r0_data, 128'h60);

    // Reset one cycle after the grant kills the access
    applyStimulus(1, 1, 5'h7, 4'h0, 0, 5'h0, 4'h0);
    applyStimulus(0, 0, 5'h0, 4'h0, 0, 5'h0, 4'h0);
    seen_v0 = 0; seen_v1 = 0;
    idle(5);
    checkOutput("t6_no_pulse", seen_v0 + seen_v1, 0);

    // Random traffic with occasional drops, address changes and resets
    q0 = 0; q1 = 0; a0 = 0; a1 = 0; e0 = 0; e1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!q0 || m_ack0) begin
        q0 = ($urandom_range(0, 3) != 0);
        a0 = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 31));
        e0 = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 9) == 0) begin
        q0 = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        a0 = 5'($urandom_range(0, 31));
      end
      if (!q1 || m_ack1) begin
        q1 = ($urandom_range(0, 3) != 0);
        a1 = ($urandom_range(0, 7) == 0) ? 5'h1F : 5'($urandom_range(0, 31));
        e1 = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 9) == 0) begin
        q1 = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        a1 = 5'($urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 79) != 0);
      applyStimulus(rst, q0, a0, e0, q1, a1, e1);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
